// File: rtl/lsu_mem_arbiter_if.sv
// Handshake bundle between the LSU request ports, the arbiter and the data memory channels.
interface lsu_mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 16,
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_addr;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_addr;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    // Arbiter view: answers the LSUs and drives the memory channels.
    modport master (
        input  consumer_read_valid, consumer_read_addr,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_addr, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    // Environment view: the LSUs together with the memory model.
    modport slave (
        output consumer_read_valid, consumer_read_addr,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_addr, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Maps LSU read/write requests onto the data memory channels, one transaction per channel.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | searching consumers from rr+1 for an unclaimed request
// READ_WAIT  | mem_read_valid held until the memory returns data
// WRITE_WAIT | mem_write_valid held until the memory accepts the write
// RELAY      | consumer ready held until the consumer drops its valid
module lsu_mem_arbiter #(
    parameter int NUM_CONSUMERS = 16,
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic clk,
    input  logic reset,
    lsu_mem_arbiter_if.master bus
);
    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [IDX_BITS:0] NC_W = (IDX_BITS+1)'(NUM_CONSUMERS);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t                state_q    [NUM_CHANNELS];
    state_t                state_d    [NUM_CHANNELS];
    logic [IDX_BITS-1:0]   owner_q    [NUM_CHANNELS];
    logic [IDX_BITS-1:0]   owner_d    [NUM_CHANNELS];
    logic [IDX_BITS-1:0]   rr_q       [NUM_CHANNELS];
    logic [IDX_BITS-1:0]   rr_d       [NUM_CHANNELS];
    logic                  is_write_q [NUM_CHANNELS];
    logic                  is_write_d [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]  addr_q     [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]  addr_d     [NUM_CHANNELS];
    // Write data while in WRITE_WAIT, captured read data while relaying a read.
    logic [DATA_BITS-1:0]  data_q     [NUM_CHANNELS];
    logic [DATA_BITS-1:0]  data_d     [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] claim_q, claim_d;

    logic [NUM_CONSUMERS-1:0] taken;
    logic [NUM_CONSUMERS-1:0] freed;
    logic                     found;
    logic [IDX_BITS:0]        wide;
    logic [IDX_BITS-1:0]      sel;

    // State register: every channel's FSM, pointers, latched transaction and claim bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]    <= IDLE;
                owner_q[c]    <= '0;
                rr_q[c]       <= '0;
                is_write_q[c] <= 1'b0;
                addr_q[c]     <= '0;
                data_q[c]     <= '0;
            end
            claim_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]    <= state_d[c];
                owner_q[c]    <= owner_d[c];
                rr_q[c]       <= rr_d[c];
                is_write_q[c] <= is_write_d[c];
                addr_q[c]     <= addr_d[c];
                data_q[c]     <= data_d[c];
            end
            claim_q <= claim_d;
        end
    end

    // Next state: channels arbitrate in index order so lower channels' grants hide consumers from higher ones.
    always_comb begin
        taken = claim_q;
        freed = '0;
        found = 1'b0;
        wide  = '0;
        sel   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c]    = state_q[c];
            owner_d[c]    = owner_q[c];
            rr_d[c]       = rr_q[c];
            is_write_d[c] = is_write_q[c];
            addr_d[c]     = addr_q[c];
            data_d[c]     = data_q[c];
            unique case (state_q[c])
                IDLE: begin
                    found = 1'b0;
                    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
                        wide = {1'b0, rr_q[c]} + (IDX_BITS+1)'(k);
                        if (wide >= NC_W) wide = wide - NC_W;
                        sel = wide[IDX_BITS-1:0];
                        if (!found && !taken[sel] &&
                            (bus.consumer_read_valid[sel] || bus.consumer_write_valid[sel])) begin
                            found      = 1'b1;
                            taken[sel] = 1'b1;
                            owner_d[c] = sel;
                            rr_d[c]    = sel;
                            if (bus.consumer_read_valid[sel]) begin
                                state_d[c]    = READ_WAIT;
                                is_write_d[c] = 1'b0;
                                addr_d[c]     = bus.consumer_read_addr[sel];
                                data_d[c]     = '0;
                            end else begin
                                state_d[c]    = WRITE_WAIT;
                                is_write_d[c] = 1'b1;
                                addr_d[c]     = bus.consumer_write_addr[sel];
                                data_d[c]     = bus.consumer_write_data[sel];
                            end
                        end
                    end
                end
                READ_WAIT: begin
                    if (bus.mem_read_ready[c]) begin
                        state_d[c] = RELAY;
                        data_d[c]  = bus.mem_read_data[c];
                    end
                end
                WRITE_WAIT: begin
                    if (bus.mem_write_ready[c]) state_d[c] = RELAY;
                end
                RELAY: begin
                    if (is_write_q[c] ? !bus.consumer_write_valid[owner_q[c]]
                                      : !bus.consumer_read_valid[owner_q[c]]) begin
                        state_d[c]        = IDLE;
                        freed[owner_q[c]] = 1'b1;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
        // Freed consumers stay in taken this cycle, so they are re-granted one cycle later at the earliest.
        claim_d = taken & ~freed;
    end

    // Outputs: decoded from registered state, so everything follows the edge that changed the state.
    always_comb begin
        bus.consumer_read_ready  = '0;
        bus.consumer_read_data   = '0;
        bus.consumer_write_ready = '0;
        bus.mem_read_valid       = '0;
        bus.mem_read_address     = '0;
        bus.mem_write_valid      = '0;
        bus.mem_write_address    = '0;
        bus.mem_write_data       = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            unique case (state_q[c])
                READ_WAIT: begin
                    bus.mem_read_valid[c]   = 1'b1;
                    bus.mem_read_address[c] = addr_q[c];
                end
                WRITE_WAIT: begin
                    bus.mem_write_valid[c]   = 1'b1;
                    bus.mem_write_address[c] = addr_q[c];
                    bus.mem_write_data[c]    = data_q[c];
                end
                RELAY: begin
                    if (is_write_q[c]) begin
                        bus.consumer_write_ready[owner_q[c]] = 1'b1;
                    end else begin
                        bus.consumer_read_ready[owner_q[c]] = 1'b1;
                        bus.consumer_read_data[owner_q[c]]  = data_q[c];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: table of single transactions, hand-written corner sequences, scoreboard of expected data.
module tb_lsu_mem_arbiter;
    localparam int NC  = 16;
    localparam int NCH = 4;
    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int GAP_LIMIT = 96;

    typedef struct {
        int          cons;
        bit          wr;
        logic [AB-1:0] addr;
        logic [DB-1:0] wdata;
        logic [DB-1:0] exp;
    } vec_t;

    typedef struct {
        int          cons;
        bit          wr;
        logic [DB-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [DB-1:0] mem   [256];
    logic [DB-1:0] model [256];
    logic stall;
    logic force_rdy;
    exp_t sb [$];
    bit   auto_rereq;
    bit   cool [NC];
    int   served [NC];
    int   last_serv [NC];
    int   max_gap;
    int   cyc;

    always #5 clk = ~clk;

    lsu_mem_arbiter_if #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    lsu_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Memory model: zero-wait unless stalled; force_rdy drives ready regardless of valid.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            bus.mem_read_ready[c]  = (bus.mem_read_valid[c] && !stall) || force_rdy;
            bus.mem_write_ready[c] = (bus.mem_write_valid[c] && !stall) || force_rdy;
            bus.mem_read_data[c]   = mem[bus.mem_read_address[c]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue_read(input int c, input logic [AB-1:0] a);
        bus.consumer_read_valid[c] = 1'b1;
        bus.consumer_read_addr[c]  = a;
        sb.push_back('{cons: c, wr: 1'b0, data: model[a]});
    endtask

    task automatic issue_write(input int c, input logic [AB-1:0] a, input logic [DB-1:0] d);
        bus.consumer_write_valid[c] = 1'b1;
        bus.consumer_write_addr[c]  = a;
        bus.consumer_write_data[c]  = d;
        model[a] = d;
        sb.push_back('{cons: c, wr: 1'b1, data: d});
    endtask

    task automatic sb_take(input int c, input bit wr, input logic [DB-1:0] act);
        int idx;
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
            if (idx < 0 && sb[k].cons == c && sb[k].wr == wr) idx = k;
        check($sformatf("sb_hit_c%0d_wr%0d", c, wr), 32'(idx >= 0), 1);
        if (idx >= 0) begin
            if (!wr) check($sformatf("rd_data_c%0d", c), act, sb[idx].data);
            sb.delete(idx);
        end
    endtask

    task automatic note_served(input int c);
        served[c]++;
        if (cyc - last_serv[c] > max_gap) max_gap = cyc - last_serv[c];
        last_serv[c] = cyc;
    endtask

    // One negedge worth of LSU behaviour plus memory writes and per-cycle invariants.
    task automatic service();
        cyc++;
        for (int ch = 0; ch < NCH; ch++)
            if (bus.mem_write_valid[ch] && bus.mem_write_ready[ch])
                mem[bus.mem_write_address[ch]] = bus.mem_write_data[ch];
        for (int a = 0; a < NCH; a++)
            for (int b = a + 1; b < NCH; b++)
                if (bus.mem_read_valid[a] && bus.mem_read_valid[b])
                    check("distinct_rd_addr", 32'(bus.mem_read_address[a] == bus.mem_read_address[b]), 0);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("rd_ready_no_valid_c%0d", c),
                  32'(bus.consumer_read_ready[c] & ~bus.consumer_read_valid[c]), 0);
            check($sformatf("wr_ready_no_valid_c%0d", c),
                  32'(bus.consumer_write_ready[c] & ~bus.consumer_write_valid[c]), 0);
            if (bus.consumer_read_ready[c] && bus.consumer_read_valid[c]) begin
                sb_take(c, 1'b0, bus.consumer_read_data[c]);
                bus.consumer_read_valid[c] = 1'b0;
                note_served(c);
                cool[c] = auto_rereq;
            end else if (cool[c] && !bus.consumer_read_valid[c]) begin
                cool[c] = 1'b0;
                if (auto_rereq) issue_read(c, AB'(c));
            end
            if (bus.consumer_write_ready[c] && bus.consumer_write_valid[c]) begin
                sb_take(c, 1'b1, 8'h00);
                bus.consumer_write_valid[c] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        service();
    endtask

    task automatic drain(input int budget, input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check({name, "_pending_left"}, sb.size(), 0);
        repeat (2) tick();
    endtask

    // Single transaction on an idle arbiter: channel 0 takes it, cycle-exact latency.
    task automatic run_vec(input vec_t v, input string name);
        if (v.wr) issue_write(v.cons, v.addr, v.wdata);
        else      issue_read(v.cons, v.addr);
        @(negedge clk);
        if (v.wr) begin
            check({name, "_mem_wr_valid"}, bus.mem_write_valid[0], 1);
            check({name, "_mem_wr_addr"}, bus.mem_write_address[0], v.addr);
            check({name, "_mem_wr_data"}, bus.mem_write_data[0], v.wdata);
        end else begin
            check({name, "_mem_rd_valid"}, bus.mem_read_valid[0], 1);
            check({name, "_mem_rd_addr"}, bus.mem_read_address[0], v.addr);
        end
        service();
        @(negedge clk);
        if (v.wr) begin
            check({name, "_wr_ready"}, bus.consumer_write_ready[v.cons], 1);
            check({name, "_mem_wr_dropped"}, bus.mem_write_valid[0], 0);
        end else begin
            check({name, "_rd_ready"}, bus.consumer_read_ready[v.cons], 1);
            check({name, "_rd_data"}, bus.consumer_read_data[v.cons], v.exp);
            check({name, "_mem_rd_dropped"}, bus.mem_read_valid[0], 0);
        end
        service();
        @(negedge clk);
        check({name, "_released"}, 32'(bus.consumer_read_ready[v.cons] | bus.consumer_write_ready[v.cons]), 0);
        service();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        vecs[0] = '{cons: 3,  wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp: 8'h5A};
        vecs[1] = '{cons: 7,  wr: 1'b1, addr: 8'h20, wdata: 8'h33, exp: 8'h00};
        vecs[2] = '{cons: 1,  wr: 1'b0, addr: 8'h20, wdata: 8'h00, exp: 8'h33};
        vecs[3] = '{cons: 15, wr: 1'b0, addr: 8'h00, wdata: 8'h00, exp: 8'hA5};
        vecs[4] = '{cons: 0,  wr: 1'b1, addr: 8'hFF, wdata: 8'hC3, exp: 8'h00};
        vecs[5] = '{cons: 0,  wr: 1'b0, addr: 8'hFF, wdata: 8'h00, exp: 8'hC3};
        vecs[6] = '{cons: 8,  wr: 1'b0, addr: 8'h03, wdata: 8'h00, exp: 8'hA6};

        reset = 1'b0;
        stall = 1'b0;
        force_rdy = 1'b0;
        auto_rereq = 1'b0;
        bus.consumer_read_valid  = '0;
        bus.consumer_read_addr   = '0;
        bus.consumer_write_valid = '0;
        bus.consumer_write_addr  = '0;
        bus.consumer_write_data  = '0;
        for (int a = 0; a < 256; a++) begin
            mem[a]   = DB'(a) ^ 8'hA5;
            model[a] = DB'(a) ^ 8'hA5;
        end
        mem[8'h10]   = 8'h5A;
        model[8'h10] = 8'h5A;
        for (int c = 0; c < NC; c++) begin
            cool[c] = 1'b0;
            served[c] = 0;
            last_serv[c] = 0;
        end
        cyc = 0;
        max_gap = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd_valid", bus.mem_read_valid, 0);
        check("rst_mem_wr_valid", bus.mem_write_valid, 0);
        check("rst_mem_rd_addr", bus.mem_read_address, 0);
        check("rst_cons_rd_ready", bus.consumer_read_ready, 0);
        check("rst_cons_wr_ready", bus.consumer_write_ready, 0);
        check("rst_cons_rd_data", 32'(|bus.consumer_read_data), 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Four reads at once fill all four channels in one cycle.
        for (int c = 0; c < 4; c++) issue_read(c, AB'(c));
        @(negedge clk);
        check("quad_mem_rd_valid", bus.mem_read_valid, 4'hF);
        service();
        @(negedge clk);
        check("quad_rd_ready", bus.consumer_read_ready[3:0], 4'hF);
        service();
        drain(20, "quad");

        // Six reads: four granted, two wait for free channels.
        for (int c = 0; c < 6; c++) issue_read(c, AB'(8'h40 + c));
        @(negedge clk);
        check("six_mem_rd_valid", bus.mem_read_valid, 4'hF);
        service();
        @(negedge clk);
        check("six_first_ready_count", $countones(bus.consumer_read_ready), 4);
        service();
        drain(40, "six");

        // Read and write from one consumer together: read first, write later.
        issue_read(5, 8'h30);
        issue_write(5, 8'h31, 8'h77);
        @(negedge clk);
        check("both_rd_first", bus.mem_read_valid[0], 1);
        check("both_no_wr_yet", bus.mem_write_valid, 0);
        service();
        drain(30, "both");
        check("both_wr_landed", mem[8'h31], 8'h77);

        // Memory ready while relaying must not overwrite the returned data.
        issue_read(9, 8'h50);
        tick();
        @(negedge clk);
        check("stray_ready_initial", bus.consumer_read_ready[9], 1);
        force_rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            check("stray_ready_hold", bus.consumer_read_ready[9], 1);
            check("stray_ready_data", bus.consumer_read_data[9], 8'hF5);
        end
        force_rdy = 1'b0;
        service();
        tick();
        check("stray_ready_released", bus.consumer_read_ready[9], 0);

        // Reset while channel 0 waits on a stalled memory.
        stall = 1'b1;
        issue_read(2, 8'h05);
        tick();
        tick();
        check("rst_mid_wait_valid", bus.mem_read_valid[0], 1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_rd_valid", bus.mem_read_valid, 0);
        check("rst_mid_mem_rd_addr", bus.mem_read_address, 0);
        check("rst_mid_cons_rd_ready", bus.consumer_read_ready, 0);
        check("rst_mid_cons_rd_data", 32'(|bus.consumer_read_data), 0);
        bus.consumer_read_valid[2] = 1'b0;
        sb.delete();
        stall = 1'b0;
        reset = 1'b1;
        tick();
        run_vec('{cons: 2, wr: 1'b0, addr: 8'h06, wdata: 8'h00, exp: 8'hA3}, "post_rst");

        // All consumers re-request continuously; every one must be served without long gaps.
        for (int c = 0; c < NC; c++) begin
            served[c] = 0;
            last_serv[c] = cyc;
            cool[c] = 1'b0;
        end
        max_gap = 0;
        auto_rereq = 1'b1;
        for (int c = 0; c < NC; c++) issue_read(c, AB'(c));
        repeat (200) tick();
        auto_rereq = 1'b0;
        drain(100, "fair");
        for (int c = 0; c < NC; c++)
            check($sformatf("fair_served_c%0d_ge2_count%0d", c, served[c]), 32'(served[c] >= 2), 1);
        check($sformatf("fair_gap_le%0d_max%0d", GAP_LIMIT, max_gap), 32'(max_gap <= GAP_LIMIT), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
